// File: rtl/variable_pkg.sv
// Shared game constants: power-bar placement per player, direction/state enums and bar colours.
package variable_pkg;

  localparam int PKG_PLAYERS  = 2;
  localparam int PLAYER_IDX_W = 1;

  typedef enum logic {LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, UP, DOWN, LOCKED} power_state_t;

  localparam logic [11:0] POWER_YPOS   = 12'd40;
  localparam logic [11:0] POWER_HEIGHT = 12'd8;

  // Player 0 grows leftwards from its anchor, player 1 rightwards.
  localparam logic [11:0] POWER_XPOS [PKG_PLAYERS] = '{12'd300, 12'd340};
  localparam dir_t        POWER_DIR  [PKG_PLAYERS] = '{LEFT, RIGHT};

  localparam logic [11:0] COLOR_GREEN  = 12'h2c2;
  localparam logic [11:0] COLOR_YELLOW = 12'hea2;
  localparam logic [11:0] COLOR_RED    = 12'he22;

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour bundle passed between overlay stages.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/power_meter_ctrl.sv
// Frame-tick detection, step divider, ping-pong/lock FSM and latched shot power.
// power/power_valid are registered one cycle after the release is sampled.
module power_meter_ctrl
  import variable_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int POWER_W         = 5,
  parameter int FRAMES_PER_STEP = 2,
  parameter int HOLD_FRAMES     = 60,
  parameter int PW              = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic               clk60MHz,
  input  logic               rst_n,
  input  logic               i_vblnk,
  input  logic               i_charge,
  input  logic [PW-1:0]      i_player,
  output logic [1:0]         o_state,
  output logic [PW-1:0]      o_player,
  output logic [POWER_W-1:0] o_value,
  output logic [POWER_W-1:0] o_power,
  output logic               o_power_valid
);

  localparam int DIV_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(FRAMES_PER_STEP - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [POWER_W-1:0] CNT_MAX   = '1;

  power_state_t       r_state;
  logic               r_vblnk_d;
  logic [PW-1:0]      r_player;
  logic [POWER_W-1:0] r_cnt;
  logic [POWER_W-1:0] r_power;
  logic               r_power_valid;
  logic [DIV_W-1:0]   r_div;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_armed;

  logic w_tick;
  logic w_step;
  logic w_abort;

  assign w_tick  = i_vblnk & ~r_vblnk_d;
  assign w_step  = w_tick && (r_div == DIV_LAST);
  // A player change or an out-of-range player drops any charge without a pulse.
  assign w_abort = (int'(i_player) >= NUM_PLAYERS) ||
                   ((i_player != r_player) && (r_state != IDLE));

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_vblnk_d     <= 1'b0;
      r_player      <= '0;
      r_cnt         <= '0;
      r_power       <= '0;
      r_power_valid <= 1'b0;
      r_div         <= '0;
      r_hold        <= '0;
      r_armed       <= 1'b0;
    end else begin
      r_vblnk_d     <= i_vblnk;
      r_player      <= i_player;
      r_power_valid <= 1'b0;
      if (w_tick) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      end

      if (w_abort) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_div   <= '0;
        r_hold  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt <= '0;
            if (!i_charge) begin
              r_armed <= 1'b1;
            end else if (r_armed) begin
              r_state <= UP;
              r_armed <= 1'b0;
              r_div   <= '0;
            end
          end
          UP, DOWN: begin
            // Release wins over a same-cycle step so the shown value is latched.
            if (!i_charge) begin
              r_state       <= LOCKED;
              r_power       <= r_cnt;
              r_power_valid <= 1'b1;
              r_hold        <= '0;
              r_div         <= '0;
            end else if (w_step) begin
              if (r_state == UP) begin
                if (r_cnt == CNT_MAX) begin
                  r_cnt   <= r_cnt - 1'b1;
                  r_state <= DOWN;
                  r_div   <= '0;
                end else begin
                  r_cnt <= r_cnt + 1'b1;
                end
              end else begin
                if (r_cnt == '0) begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= UP;
                  r_div   <= '0;
                end else begin
                  r_cnt <= r_cnt - 1'b1;
                end
              end
            end
          end
          LOCKED: begin
            if (w_tick) begin
              if (r_hold == HOLD_LAST) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_hold  <= '0;
                r_div   <= '0;
              end else begin
                r_hold <= r_hold + 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_state       = r_state;
  assign o_player      = r_player;
  assign o_value       = (r_state == LOCKED) ? r_power : r_cnt;
  assign o_power       = r_power;
  assign o_power_valid = r_power_valid;

endmodule

// File: rtl/power_meter_draw.sv
// Shot-power meter overlay: charge FSM plus per-player power bar, 1-cycle video latency.
// POWER_GRADIENT_EN selects a value-dependent bar colour; otherwise the bar is solid yellow.
module power_meter_draw
  import variable_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int POWER_W         = 5,
  parameter int STEP_PX         = 4,
  parameter int FRAMES_PER_STEP = 2,
  parameter int HOLD_FRAMES     = 60,
  localparam int PW             = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic               clk60MHz,
  input  logic               rst_n,
  input  logic               charge,
  input  logic [PW-1:0]      current_player,
  output logic [POWER_W-1:0] power,
  output logic               power_valid,
  vga_if.in                  in,
  vga_if.out                 out
);

  logic [1:0]              w_state;
  logic [PW-1:0]           w_player;
  logic [POWER_W-1:0]      w_value;
  logic [PLAYER_IDX_W-1:0] w_pidx;
  logic [11:0]             w_width;
  logic [11:0]             w_xpos;
  logic [11:0]             w_left;
  logic [12:0]             w_right;
  logic [11:0]             w_x;
  logic [11:0]             w_y;
  logic                    w_in_x;
  logic                    w_in_y;
  logic                    w_draw;
  logic [11:0]             w_colour;

  power_meter_ctrl #(
    .NUM_PLAYERS     (NUM_PLAYERS),
    .POWER_W         (POWER_W),
    .FRAMES_PER_STEP (FRAMES_PER_STEP),
    .HOLD_FRAMES     (HOLD_FRAMES),
    .PW              (PW)
  ) u_ctrl (
    .clk60MHz      (clk60MHz),
    .rst_n         (rst_n),
    .i_vblnk       (in.vblnk),
    .i_charge      (charge),
    .i_player      (current_player),
    .o_state       (w_state),
    .o_player      (w_player),
    .o_value       (w_value),
    .o_power       (power),
    .o_power_valid (power_valid)
  );

  assign w_pidx = PLAYER_IDX_W'(w_player);

  always_comb begin
    w_xpos  = POWER_XPOS[w_pidx];
    w_width = 12'(w_value) * 12'(STEP_PX);
    w_x     = {1'b0, in.hcount};
    w_y     = {1'b0, in.vcount};
    // Left-growing bars clamp at column 0 instead of wrapping.
    w_left  = (w_xpos >= w_width) ? (w_xpos - w_width) : 12'd0;
    w_right = {1'b0, w_xpos} + {1'b0, w_width};
    w_in_y  = (w_y >= POWER_YPOS) && (w_y <= POWER_YPOS + POWER_HEIGHT);
    if (POWER_DIR[w_pidx] == LEFT) begin
      w_in_x = (w_x >= w_left) && (w_x <= w_xpos);
    end else begin
      w_in_x = (w_x >= w_xpos) && ({1'b0, w_x} <= w_right);
    end
    w_draw = (w_state != IDLE) && w_in_x && w_in_y && !in.hblnk && !in.vblnk;
  end

`ifdef POWER_GRADIENT_EN
  localparam int POWER_MAX = 2**POWER_W - 1;
  localparam logic [POWER_W-1:0] GRAD_LO = POWER_W'(POWER_MAX / 3);
  localparam logic [POWER_W-1:0] GRAD_HI = POWER_W'(2 * POWER_MAX / 3);

  always_comb begin
    w_colour = COLOR_RED;
    if (w_value <= GRAD_LO) begin
      w_colour = COLOR_GREEN;
    end else if (w_value <= GRAD_HI) begin
      w_colour = COLOR_YELLOW;
    end
  end
`else
  assign w_colour = COLOR_YELLOW;
`endif

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      out.vcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.vcount <= in.vcount;
      out.vsync  <= in.vsync;
      out.vblnk  <= in.vblnk;
      out.hcount <= in.hcount;
      out.hsync  <= in.hsync;
      out.hblnk  <= in.hblnk;
      out.rgb    <= w_draw ? w_colour : in.rgb;
    end
  end

endmodule

// File: tb/tb_power_meter_draw.sv
// Directed bench for power_meter_draw: short synthetic frames, bar geometry and power latch checks.
module tb_power_meter_draw;

  localparam logic [11:0] BG = 12'h123;

  logic       clk60MHz = 1'b0;
  logic       rst_n;
  logic       charge;
  logic [0:0] current_player;
  logic [4:0] power;
  logic       power_valid;

  int n_pass   = 0;
  int n_fail   = 0;
  int n_total  = 0;
  int n_pulses = 0;

  vga_if vin ();
  vga_if vout ();

  power_meter_draw #(
    .NUM_PLAYERS     (2),
    .POWER_W         (5),
    .STEP_PX         (4),
    .FRAMES_PER_STEP (2),
    .HOLD_FRAMES     (60)
  ) dut (
    .clk60MHz       (clk60MHz),
    .rst_n          (rst_n),
    .charge         (charge),
    .current_player (current_player),
    .power          (power),
    .power_valid    (power_valid),
    .in             (vin),
    .out            (vout)
  );

  always #5 clk60MHz = ~clk60MHz;

  always @(negedge clk60MHz) begin
    if (power_valid === 1'b1) n_pulses++;
  end

  function automatic logic [11:0] bar_col(input int v);
`ifdef POWER_GRADIENT_EN
    if (v <= 10) return 12'h2c2;
    else if (v <= 20) return 12'hea2;
    else return 12'he22;
`else
    return 12'hea2;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk60MHz);
    #1;
  endtask

  // One synthetic frame: 2 cycles of vblank, 2 cycles active, exactly one tick.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vin.vblnk = 1'b1;
      clk1();
      clk1();
      vin.vblnk = 1'b0;
      clk1();
      clk1();
    end
  endtask

  task automatic px(input string tag, input int x, input int y, input bit on, input int v);
    vin.hcount = 11'(x);
    vin.vcount = 11'(y);
    vin.rgb    = BG;
    clk1();
    check(tag, 32'(vout.rgb), on ? 32'(bar_col(v)) : 32'(BG));
    vin.hcount = '0;
    vin.vcount = '0;
  endtask

  initial begin
    rst_n          = 1'b0;
    charge         = 1'b0;
    current_player = 1'b0;
    vin.hcount     = 11'd5;
    vin.vcount     = 11'd7;
    vin.hsync      = 1'b1;
    vin.vsync      = 1'b1;
    vin.hblnk      = 1'b0;
    vin.vblnk      = 1'b0;
    vin.rgb        = 12'habc;
    repeat (3) clk1();
    check("rst_rgb", 32'(vout.rgb), 32'h0);
    check("rst_hcount", 32'(vout.hcount), 32'h0);
    check("rst_hsync", 32'(vout.hsync), 32'h0);
    check("rst_power", 32'(power), 32'h0);
    check("rst_valid", 32'(power_valid), 32'h0);

    rst_n = 1'b1;
    clk1();
    check("pass_rgb", 32'(vout.rgb), 32'habc);
    check("pass_hcount", 32'(vout.hcount), 32'd5);
    check("pass_vcount", 32'(vout.vcount), 32'd7);
    check("pass_hsync", 32'(vout.hsync), 32'h1);
    vin.hcount = '0;
    vin.vcount = '0;
    vin.hsync  = 1'b0;
    vin.vsync  = 1'b0;
    vin.rgb    = BG;
    clk1();

    // Player 0, LEFT at 300: 10 frames -> 5 steps -> bar 280..300
    charge = 1'b1;
    clk1();
    px("up0_anchor", 300, 44, 1, 0);
    px("up0_left", 299, 44, 0, 0);
    frames(10);
    px("c5_lo", 280, 44, 1, 5);
    px("c5_lo_out", 279, 44, 0, 5);
    px("c5_hi", 300, 44, 1, 5);
    px("c5_hi_out", 301, 44, 0, 5);
    px("c5_top", 290, 40, 1, 5);
    px("c5_top_out", 290, 39, 0, 5);
    px("c5_bot", 290, 48, 1, 5);
    px("c5_bot_out", 290, 49, 0, 5);
    vin.hblnk = 1'b1;
    px("c5_hblnk", 290, 44, 0, 5);
    vin.hblnk = 1'b0;
    charge = 1'b0;
    clk1();
    check("rel5_valid", 32'(power_valid), 32'h1);
    check("rel5_power", 32'(power), 32'd5);
    clk1();
    check("rel5_valid_end", 32'(power_valid), 32'h0);
    px("lock5", 280, 44, 1, 5);
    for (int i = 0; i < 59; i++) begin
      charge = (i >= 10 && i < 20);
      frames(1);
    end
    charge = 1'b0;
    px("lock_f59", 280, 44, 1, 5);
    check("lock_pulses", 32'(n_pulses), 32'd1);
    frames(1);
    px("lock_gone", 300, 44, 0, 5);
    check("power_hold", 32'(power), 32'd5);
    frames(1);
    px("idle_stays", 300, 44, 0, 0);

    // Ping-pong across both bounds
    charge = 1'b1;
    clk1();
    frames(62);
    px("pp31", 176, 44, 1, 31);
    px("pp31_out", 175, 44, 0, 31);
    frames(2);
    px("pp30", 180, 44, 1, 30);
    px("pp30_out", 179, 44, 0, 30);
    frames(4);
    px("pp28", 188, 44, 1, 28);
    px("pp28_out", 187, 44, 0, 28);
    frames(16);
    px("pp20", 220, 44, 1, 20);
    px("pp20_out", 219, 44, 0, 20);
    frames(20);
    px("pp10", 260, 44, 1, 10);
    px("pp10_out", 259, 44, 0, 10);
    frames(20);
    px("pp0", 300, 44, 1, 0);
    px("pp0_out", 299, 44, 0, 0);
    frames(2);
    px("pp1", 296, 44, 1, 1);
    px("pp1_out", 295, 44, 0, 1);
    frames(2);
    px("pp2", 292, 44, 1, 2);
    charge = 1'b0;
    clk1();
    check("rel2_power", 32'(power), 32'd2);
    check("rel2_valid", 32'(power_valid), 32'h1);
    frames(60);
    px("rel2_gone", 292, 44, 0, 2);

    // Release on the same cycle as a step, counter 7
    charge = 1'b1;
    clk1();
    frames(15);
    vin.vblnk = 1'b1;
    charge    = 1'b0;
    clk1();
    check("rel7_power", 32'(power), 32'd7);
    check("rel7_valid", 32'(power_valid), 32'h1);
    clk1();
    vin.vblnk = 1'b0;
    clk1();
    clk1();
    px("lock7", 272, 44, 1, 7);
    px("lock7_out", 271, 44, 0, 7);
    frames(60);
    check("pulses3", 32'(n_pulses), 32'd3);

    // Player switch mid-charge, then player 1 RIGHT at 340
    charge = 1'b1;
    clk1();
    frames(6);
    px("p0_c3", 288, 44, 1, 3);
    px("p0_c3_out", 287, 44, 0, 3);
    current_player = 1'b1;
    clk1();
    px("sw_p1_none", 340, 44, 0, 0);
    px("sw_p0_none", 300, 44, 0, 0);
    check("sw_pulses", 32'(n_pulses), 32'd3);
    check("sw_power", 32'(power), 32'd7);
    charge = 1'b0;
    clk1();
    charge = 1'b1;
    clk1();
    frames(6);
    px("p1_lo", 340, 44, 1, 3);
    px("p1_hi", 352, 44, 1, 3);
    px("p1_hi_out", 353, 44, 0, 3);
    px("p1_lo_out", 339, 44, 0, 3);
    charge = 1'b0;
    clk1();
    check("rel3_power", 32'(power), 32'd3);
    check("rel3_valid", 32'(power_valid), 32'h1);
    frames(60);
    check("pulses4", 32'(n_pulses), 32'd4);

    // Reset asserted mid-charge
    charge = 1'b1;
    clk1();
    frames(4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_power", 32'(power), 32'h0);
    check("mid_rst_valid", 32'(power_valid), 32'h0);
    check("mid_rst_rgb", 32'(vout.rgb), 32'h0);
    charge = 1'b0;
    clk1();
    rst_n = 1'b1;
    clk1();
    px("after_rst_none", 344, 44, 0, 0);
    check("after_rst_pulses", 32'(n_pulses), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/power_meter_draw.md
# power_meter_draw

Parametrised shot-power meter for the turn-based game: samples the active player's charge button and runs a ping-pong power counter paced by video frames. On release it latches the shot power and overlays a per-player power bar on the VGA stream. It sits in the VGA overlay chain after the background and sprite stages. It delivers a latched power value and a one-cycle valid pulse to the game logic.

## Interface
- NUM_PLAYERS, 2: players sharing the meter; `current_player` index range.
- POWER_W, 5: power counter width; POWER_MAX = 2**POWER_W-1.
- STEP_PX, 4: bar pixels per power unit.
- FRAMES_PER_STEP, 2: frames per power increment/decrement (≥1).
- HOLD_FRAMES, 60: frames the locked bar stays visible after release (≥1).
- clk60MHz  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- charge  in  1  charge button level, already synchronised/debounced; high = charging.
- current_player  in  $clog2(NUM_PLAYERS)  active player index.
- power  out  POWER_W  latched shot power; holds until next release.
- power_valid  out  1  one-cycle pulse when `power` is latched.
- in  vga_if.in  —  upstream timing + rgb.
- out  vga_if.out  —  delayed timing + overlaid rgb.

## Operation
- Frame tick: one-cycle pulse on the rising edge of `in.vblnk`, detected with a registered copy.
- Step divider counts ticks 0..FRAMES_PER_STEP-1. A step fires when the divider wraps. It clears on every state entry.
- FSM states:
  - IDLE: power counter 0, no bar. `charge`=1 → UP, counter 0.
  - UP: on step, +1. On a step with counter==POWER_MAX: counter−1 and go DOWN.
  - DOWN: on step, −1. On a step with counter==0: counter+1 and go UP.
  - UP/DOWN: `charge`=0 on any cycle → LOCKED. `power`<=counter, `power_valid`=1 on the following cycle. Release takes priority over a same-cycle step; the pre-step value is latched.
  - LOCKED: `charge` ignored. After HOLD_FRAMES ticks → IDLE. Re-charge requires `charge` low then high.
- `current_player` change while in UP/DOWN/LOCKED → IDLE next cycle, no `power_valid`.
- `current_player` ≥ NUM_PLAYERS: FSM held in IDLE, no bar.
- Bar is drawn in UP, DOWN and LOCKED. The displayed value is the counter, or `power` in LOCKED.
  - Width W = value*STEP_PX, computed 12-bit unsigned.
  - Rows POWER_YPOS..POWER_YPOS+POWER_HEIGHT inclusive.
  - Player with POWER_DIR[p]=LEFT covers x = max(0, POWER_XPOS[p]−W)..POWER_XPOS[p], with no underflow wrap.
  - RIGHT covers POWER_XPOS[p]..POWER_XPOS[p]+W.
  - Value 0 still draws the 1-pixel anchor column.
- Outside the bar, or during `in.hblnk`/`in.vblnk`: rgb passes through.

## Timing
- Reset values (async assert, sync release): all `out` fields 0, `power` 0, `power_valid` 0, state IDLE, counters 0.
- Video latency exactly 1 cycle for every field. Bar decision uses `in` of the same cycle and the registered state/counter.
- Counter changes only on steps, which happen within vblank, so a frame never shows a torn bar.
- `power_valid` is high for exactly 1 cycle per release. `power` is stable from that cycle on.
- Reset mid-charge: immediate return to reset values, no pulse.

## Configuration
- POWER_GRADIENT_EN defined: bar colour depends on the displayed value.
  - ≤ POWER_MAX/3 → 12'h2_c_2.
  - ≤ 2*POWER_MAX/3 → 12'he_a_2.
  - Else 12'he_2_2.
  - Integer division; compared against the value, not the pixel.
- Undefined: solid 12'he_a_2 for all values.

## Structure
- variable_pkg (shared) holds:
  - POWER_YPOS and POWER_HEIGHT.
  - POWER_XPOS[NUM_PLAYERS] and POWER_DIR[NUM_PLAYERS] arrays.
  - typedef enum for dir {LEFT, RIGHT}.
  - typedef enum power_state_t {IDLE, UP, DOWN, LOCKED}.
  - Colour constants.
- Sub-module power_meter_ctrl: frame-tick detection, divider, FSM, `power`/`power_valid`. It outputs state + display value.
- Top level does the bar geometry, colour and video register.

## Test plan
- Reset: hold rst_n=0 mid-frame → all outputs 0; release → IDLE, rgb passthrough after 1 cycle.
- Charge, FRAMES_PER_STEP=2, player 0 LEFT at x=300: hold 10 frames → counter 5, bar x=280..300. Release → `power`=5, one `power_valid` pulse.
- Ping-pong: hold 2*(31+3) frames → counter 31→30 at step 32, …, back to 28 at step 34, direction flips exactly at bounds.
- Release on the same cycle as a step, counter 7 → `power`=7.
- Player switch 0→1 mid-charge → IDLE, bar gone next frame, no pulse. Player 1 RIGHT at x=340, counter 3 → bar x=340..352.
- LOCKED with HOLD_FRAMES=60: bar visible 60 frames then removed. `charge` toggled during LOCKED → no new charge or pulse. With POWER_GRADIENT_EN, values 10/20/31 → green/yellow/red.
